// File: rtl/inv_subbytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : inv_subbytes_sched
// Function : Folded inverse-SubBytes engine shared by two requesters through
//            a round-robin arbiter; LANES bytes are substituted per cycle.
// Revision : 1.0
// ============================================================================
module inv_subbytes_sched #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s0_valid,
    output logic         s0_ready,
    input  logic [127:0] s0_data,
    input  logic         s1_valid,
    output logic         s1_ready,
    input  logic [127:0] s1_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [127:0] m_data,
    output logic         m_id,
    output logic         busy
);
    localparam int BEATS = 16 / LANES;
    localparam int BW    = 8 * LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gfinv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gmul(x, x);
        x3   = gmul(x2, x);
        x12  = gmul(gmul(x3, x3), gmul(x3, x3));
        x15  = gmul(x12, x3);
        x240 = gmul(x15, x15);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        x240 = gmul(x240, x240);
        return gmul(gmul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gfinv(b);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic          ptr_q, ptr_d;
    logic          id_q, id_d;
    logic [127:0]  buf_q, buf_d;

    logic          w_grant0, w_grant1;
    logic [BW-1:0] w_sub;
    logic [127:0]  w_next;

    assign w_grant0 = s0_valid & (~s1_valid | ~ptr_q);
    assign w_grant1 = s1_valid & (~s0_valid |  ptr_q);

    always_comb begin
        w_sub = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sub[BW-1-8*i -: 8] = inv_sbox(buf_q[127-8*i -: 8]);
        end
    end

    // The buffer rotates left one lane group per beat, so the top slice is
    // always the next one to substitute and the order is restored after BEATS.
    if (BEATS == 1) begin : g_single
        assign w_next = w_sub;
    end else begin : g_multi
        assign w_next = {buf_q[127-BW:0], w_sub};
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE: begin
                if (w_grant0 | w_grant1) begin
                    buf_d   = w_grant1 ? s1_data : s0_data;
                    id_d    = w_grant1;
                    beat_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                buf_d  = w_next;
                beat_d = beat_q + CW'(1);
                if (beat_q == LAST_BEAT) state_d = S_DONE;
            end
            S_DONE: begin
                if (m_ready) begin
                    state_d = S_IDLE;
                    ptr_d   = ~id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            buf_q   <= buf_d;
        end
    end

    assign s0_ready = (state_q == S_IDLE) & w_grant0;
    assign s1_ready = (state_q == S_IDLE) & w_grant1;
    assign m_valid  = (state_q == S_DONE);
    assign m_data   = m_valid ? buf_q : '0;
    assign m_id     = m_valid & id_q;
    assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_inv_subbytes_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_inv_subbytes_sched
// Function : Randomized scoreboard bench for inv_subbytes_sched.
// Revision : 1.0
// ============================================================================
module tb_inv_subbytes_sched;
    localparam int LANES = 4;
    localparam int BEATS = 16 / LANES;
    localparam logic [127:0] VEC1 = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] EXP1 = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         s0_valid, s1_valid, m_ready;
    logic [127:0] s0_data, s1_data;
    wire          s0_ready, s1_ready, m_valid, m_id, busy;
    wire  [127:0] m_data;

    always #5 clk = ~clk;

    inv_subbytes_sched #(.LANES(LANES)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_data(s1_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_id(m_id),
        .busy(busy)
    );

    // Wider-lane instances share one directed stimulus for the latency sweep.
    logic         tv_valid;
    logic [127:0] tv_data;
    wire          r8_rdy, r8_s1rdy, r8_mv, r8_id, r8_busy;
    wire  [127:0] r8_data;
    wire          r16_rdy, r16_s1rdy, r16_mv, r16_id, r16_busy;
    wire  [127:0] r16_data;

    inv_subbytes_sched #(.LANES(8)) u_l8 (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(tv_valid), .s0_ready(r8_rdy), .s0_data(tv_data),
        .s1_valid(1'b0), .s1_ready(r8_s1rdy), .s1_data(128'h0),
        .m_valid(r8_mv), .m_ready(1'b1), .m_data(r8_data), .m_id(r8_id),
        .busy(r8_busy)
    );

    inv_subbytes_sched #(.LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(tv_valid), .s0_ready(r16_rdy), .s0_data(tv_data),
        .s1_valid(1'b0), .s1_ready(r16_s1rdy), .s1_data(128'h0),
        .m_valid(r16_mv), .m_ready(1'b1), .m_data(r16_data), .m_id(r16_id),
        .busy(r16_busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: forward S-box built from a brute-force field inverse and the
    // forward affine map, then inverted as a lookup table.
    logic [7:0] inv_tab [256];

    function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
        int r = 0;
        int aa = a;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) r = r ^ aa;
            aa = aa << 1;
            if (aa & 256) aa = aa ^ 'h11b;
        end
        return 8'(r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] y = 8'h00;
            logic [7:0] s;
            for (int c = 1; c < 256; c++)
                if (x != 0 && fmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] d);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[d[127-8*i -: 8]];
        return r;
    endfunction

    // Scoreboard and environment state.
    logic [127:0] exp_q[$];
    logic         exp_id_q[$];
    logic [127:0] pend0[$], pend1[$];
    int           t_hs = 0;
    int           cyc = 0;
    logic         ptr_m = 1'b0;
    logic         hs0 = 1'b0, hs1 = 1'b0;
    bit           eager = 1'b0, mr_rand = 1'b0, mr_fixed = 1'b1;
    logic [127:0] last_data = '0;
    logic         last_id = 1'b0;
    int           n_out = 0, n_hs0 = 0, n_hs1 = 0;
    logic         g0, g1, idle, exp_mv;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: model-derived readies, busy and m_valid every cycle; results
    // are popped from the scoreboard when the consumer accepts.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_id_q.delete();
            ptr_m = 1'b0;
            hs0 = 1'b0;
            hs1 = 1'b0;
        end else begin
            idle = (exp_q.size() == 0);
            g0 = idle && s0_valid && (!s1_valid || !ptr_m);
            g1 = idle && s1_valid && (!s0_valid || ptr_m);
            exp_mv = !idle && ((cyc - t_hs) >= BEATS);
            chk("busy", 128'(busy), 128'(!idle));
            chk("s0_ready", 128'(s0_ready), 128'(g0));
            chk("s1_ready", 128'(s1_ready), 128'(g1));
            chk("m_valid", 128'(m_valid), 128'(exp_mv));
            if (m_valid && !idle) begin
                chk("m_data", m_data, exp_q[0]);
                chk("m_id", 128'(m_id), 128'(exp_id_q[0]));
                if (m_ready) begin
                    last_data = m_data;
                    last_id = m_id;
                    ptr_m = ~exp_id_q[0];
                    void'(exp_q.pop_front());
                    void'(exp_id_q.pop_front());
                    n_out++;
                end
            end
            hs0 = s0_valid && s0_ready;
            hs1 = s1_valid && s1_ready;
            if (hs0) begin
                exp_q.push_back(model_inv(s0_data));
                exp_id_q.push_back(1'b0);
                t_hs = cyc + 1;
                n_hs0++;
            end
            if (hs1) begin
                exp_q.push_back(model_inv(s1_data));
                exp_id_q.push_back(1'b1);
                t_hs = cyc + 1;
                n_hs1++;
            end
        end
    end

    // Requester and consumer driver: valid held until handshake.
    initial begin
        s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b1;
        s0_data = '0; s1_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                s0_valid = 1'b0;
                s1_valid = 1'b0;
            end else begin
                if (hs0) s0_valid = 1'b0;
                if (hs1) s1_valid = 1'b0;
                if (!s0_valid && pend0.size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
                    s0_data = pend0.pop_front();
                    s0_valid = 1'b1;
                end
                if (!s1_valid && pend1.size() > 0 && (eager || $urandom_range(0, 2) == 0)) begin
                    s1_data = pend1.pop_front();
                    s1_valid = 1'b1;
                end
            end
            m_ready = mr_rand ? 1'($urandom_range(0, 1)) : mr_fixed;
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(pend0.size() == 0 && pend1.size() == 0 && !s0_valid && !s1_valid &&
                     exp_q.size() == 0) && n < limit);
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL %s_timeout: waited %0d cycles, required completion", name, n);
        end
    endtask

    initial begin
        int out0, hsa, hsb, n;
        tv_valid = 1'b0;
        tv_data = '0;
        build_tables();
        rst_n = 1'b0;
        #12;
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_data", m_data, 128'(0));
        chk("rst_m_id", 128'(m_id), 128'(0));
        chk("rst_s0_ready", 128'(s0_ready), 128'(0));
        chk("rst_s1_ready", 128'(s1_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Known vector on requester 0, all-zero state on requester 1.
        pend0.push_back(VEC1);
        wait_idle("vec1", 100);
        chk("vec1_data", last_data, EXP1);
        chk("vec1_id", 128'(last_id), 128'(0));
        pend1.push_back(128'h0);
        wait_idle("zero", 100);
        chk("zero_data", last_data, {16{8'h52}});
        chk("zero_id", 128'(last_id), 128'(1));

        // Contention: both requesters continuously valid.
        eager = 1'b1;
        out0 = n_out; hsa = n_hs0; hsb = n_hs1;
        for (int i = 0; i < 6; i++) begin
            pend0.push_back(rnd128());
            pend1.push_back(rnd128());
        end
        wait_idle("contention", 400);
        chk("contention_blocks", 128'(n_out - out0), 128'(12));
        chk("contention_hs0", 128'(n_hs0 - hsa), 128'(6));
        chk("contention_hs1", 128'(n_hs1 - hsb), 128'(6));

        // Backpressure in DONE.
        eager = 1'b0;
        mr_fixed = 1'b0;
        pend1.push_back(rnd128());
        n = 0;
        while (!m_valid && n < 100) begin @(negedge clk); #1; n++; end
        chk("bp_reach_done", 128'(m_valid), 128'(1));
        repeat (10) @(negedge clk);
        #1;
        chk("bp_valid_held", 128'(m_valid), 128'(1));
        chk("bp_busy_held", 128'(busy), 128'(1));
        mr_fixed = 1'b1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 128'(m_valid), 128'(0));
        chk("bp_release_busy", 128'(busy), 128'(0));

        // Reset during RUN at beat 2.
        pend0.push_back(rnd128());
        n = 0;
        while (!busy && n < 100) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 128'(m_valid), 128'(0));
        chk("mid_rst_m_data", m_data, 128'(0));
        chk("mid_rst_m_id", 128'(m_id), 128'(0));
        chk("mid_rst_s0_ready", 128'(s0_ready), 128'(0));
        chk("mid_rst_s1_ready", 128'(s1_ready), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (6) @(negedge clk);
        eager = 1'b1;
        pend0.push_back(rnd128());
        pend1.push_back(rnd128());
        wait_idle("post_reset", 100);
        chk("post_reset_last_id", 128'(last_id), 128'(1));

        // Random traffic with random consumer backpressure.
        eager = 1'b0;
        mr_rand = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) pend0.push_back(rnd128());
            else pend1.push_back(rnd128());
        end
        wait_idle("random", 3000);
        mr_rand = 1'b0;
        mr_fixed = 1'b1;
        repeat (3) @(posedge clk);

        // Lane sweep: LANES=8 latency 2, LANES=16 latency 1.
        @(posedge clk);
        #1;
        tv_data = VEC1;
        tv_valid = 1'b1;
        @(negedge clk);
        chk("l8_ready", 128'(r8_rdy), 128'(1));
        chk("l16_ready", 128'(r16_rdy), 128'(1));
        @(posedge clk);
        #1 tv_valid = 1'b0;
        @(negedge clk);
        chk("l8_valid_t0", 128'(r8_mv), 128'(0));
        chk("l16_valid_t0", 128'(r16_mv), 128'(0));
        @(negedge clk);
        chk("l16_valid_t1", 128'(r16_mv), 128'(1));
        chk("l16_data", r16_data, EXP1);
        chk("l8_valid_t1", 128'(r8_mv), 128'(0));
        @(negedge clk);
        chk("l8_valid_t2", 128'(r8_mv), 128'(1));
        chk("l8_data", r8_data, EXP1);
        chk("l16_valid_t2", 128'(r16_mv), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
